// File: rtl/decoder.sv
// RV32I single-stage decoder: combinational decode of inst, captured in an output register (latency 1).
// Optional feature: define DECODER_RV32M_EN to decode the RV32M multiply/divide group.
package decoder_pkg;

    typedef logic [31:0] INST;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_FOUR = 2'd2
    } opb_sel_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_func_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        INST         inst;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [4:0]  dest_reg_idx;
        logic [31:0] imm;
        opa_sel_e    opa_select;
        opb_sel_e    opb_select;
        alu_func_e   alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        cond_branch;
        logic        uncond_branch;
        logic        csr_op;
        logic        halt;
        logic        illegal;
    } DECODED_PACK;

endpackage

module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  INST             inst,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    output logic            csr_op,
    output logic            halt,
    output logic            illegal,
    output DECODED_PACK     decoded_pack
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam INST        WFI_INST  = 32'h10500073;

    DECODED_PACK pack_d, pack_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        pack_d              = '0;
        pack_d.pc           = in_pc[31:0];
        pack_d.inst         = inst;
        pack_d.rs1_idx      = inst[19:15];
        pack_d.rs2_idx      = inst[24:20];
        pack_d.dest_reg_idx = inst[11:7];
        pack_d.opa_select   = OPA_RS1;
        pack_d.opb_select   = OPB_RS2;
        pack_d.alu_func     = ALU_ADD;
        ill                 = 1'b0;

        case (opcode)
            OP_LUI: begin
                pack_d.imm        = imm_u;
                pack_d.opa_select = OPA_ZERO;
                pack_d.opb_select = OPB_IMM;
            end
            OP_AUIPC: begin
                pack_d.imm        = imm_u;
                pack_d.opa_select = OPA_PC;
                pack_d.opb_select = OPB_IMM;
            end
            OP_JAL: begin
                pack_d.imm           = imm_j;
                pack_d.opa_select    = OPA_PC;
                pack_d.opb_select    = OPB_FOUR;
                pack_d.uncond_branch = 1'b1;
            end
            OP_JALR: begin
                pack_d.imm           = imm_i;
                pack_d.opa_select    = OPA_PC;
                pack_d.opb_select    = OPB_FOUR;
                pack_d.uncond_branch = 1'b1;
                ill                  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                pack_d.imm          = imm_b;
                pack_d.cond_branch  = 1'b1;
                pack_d.dest_reg_idx = '0;
                case (funct3)
                    3'b000, 3'b001: pack_d.alu_func = ALU_SUB;
                    3'b100, 3'b101: pack_d.alu_func = ALU_SLT;
                    3'b110, 3'b111: pack_d.alu_func = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                pack_d.imm        = imm_i;
                pack_d.opb_select = OPB_IMM;
                pack_d.rd_mem     = 1'b1;
                ill = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                pack_d.imm          = imm_s;
                pack_d.opb_select   = OPB_IMM;
                pack_d.wr_mem       = 1'b1;
                pack_d.dest_reg_idx = '0;
                ill = !(funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OP_OPIMM: begin
                pack_d.imm        = imm_i;
                pack_d.opb_select = OPB_IMM;
                case (funct3)
                    3'b000: pack_d.alu_func = ALU_ADD;
                    3'b010: pack_d.alu_func = ALU_SLT;
                    3'b011: pack_d.alu_func = ALU_SLTU;
                    3'b100: pack_d.alu_func = ALU_XOR;
                    3'b110: pack_d.alu_func = ALU_OR;
                    3'b111: pack_d.alu_func = ALU_AND;
                    3'b001: begin
                        pack_d.alu_func = ALU_SLL;
                        ill             = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0100000) begin
                            pack_d.alu_func = ALU_SRA;
                        end else begin
                            pack_d.alu_func = ALU_SRL;
                            ill             = (funct7 != 7'b0000000);
                        end
                    end
                endcase
            end
            OP_OP: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  pack_d.alu_func = ALU_ADD;
                            3'b001:  pack_d.alu_func = ALU_SLL;
                            3'b010:  pack_d.alu_func = ALU_SLT;
                            3'b011:  pack_d.alu_func = ALU_SLTU;
                            3'b100:  pack_d.alu_func = ALU_XOR;
                            3'b101:  pack_d.alu_func = ALU_SRL;
                            3'b110:  pack_d.alu_func = ALU_OR;
                            default: pack_d.alu_func = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  pack_d.alu_func = ALU_SUB;
                            3'b101:  pack_d.alu_func = ALU_SRA;
                            default: ill = 1'b1;
                        endcase
                    end
`ifdef DECODER_RV32M_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  pack_d.alu_func = ALU_MUL;
                            3'b001:  pack_d.alu_func = ALU_MULH;
                            3'b010:  pack_d.alu_func = ALU_MULHSU;
                            3'b011:  pack_d.alu_func = ALU_MULHU;
                            3'b100:  pack_d.alu_func = ALU_DIV;
                            3'b101:  pack_d.alu_func = ALU_DIVU;
                            3'b110:  pack_d.alu_func = ALU_REM;
                            default: pack_d.alu_func = ALU_REMU;
                        endcase
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            OP_FENCE: begin
                pack_d.dest_reg_idx = '0;
                ill                 = (funct3 != 3'b000);
            end
            OP_SYSTEM: begin
                // ECALL/EBREAK and funct3=100 fall through to illegal
                if (inst == WFI_INST) begin
                    pack_d.halt         = 1'b1;
                    pack_d.dest_reg_idx = '0;
                end else if (funct3[1:0] != 2'b00) begin
                    pack_d.csr_op = 1'b1;
                    if (funct3[2]) begin
                        pack_d.imm        = {27'd0, inst[19:15]};
                        pack_d.opa_select = OPA_ZERO;
                        pack_d.opb_select = OPB_IMM;
                    end else begin
                        pack_d.imm = imm_i;
                    end
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            pack_d.rd_mem        = 1'b0;
            pack_d.wr_mem        = 1'b0;
            pack_d.cond_branch   = 1'b0;
            pack_d.uncond_branch = 1'b0;
            pack_d.csr_op        = 1'b0;
            pack_d.halt          = 1'b0;
            pack_d.dest_reg_idx  = '0;
        end
        pack_d.illegal = ill;

        // flush wins over in_valid; an empty slot carries no control side effects
        pack_d.valid = in_valid & ~flush;
        if (!pack_d.valid) begin
            pack_d.rd_mem        = 1'b0;
            pack_d.wr_mem        = 1'b0;
            pack_d.cond_branch   = 1'b0;
            pack_d.uncond_branch = 1'b0;
            pack_d.csr_op        = 1'b0;
            pack_d.halt          = 1'b0;
            pack_d.illegal       = 1'b0;
            pack_d.dest_reg_idx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
        end else begin
            pack_q <= pack_d;
        end
    end

    assign decoded_pack = pack_q;
    assign csr_op       = pack_q.csr_op;
    assign halt         = pack_q.halt;
    assign illegal      = pack_q.illegal;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder; expectations are hand-decoded RV32 encodings.
module tb_decoder;
    import decoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    INST         inst;
    logic        flush;
    logic [31:0] in_pc;
    logic        csr_op;
    logic        halt;
    logic        illegal;
    DECODED_PACK decoded_pack;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    decoder #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .inst         (inst),
        .flush        (flush),
        .in_pc        (in_pc),
        .csr_op       (csr_op),
        .halt         (halt),
        .illegal      (illegal),
        .decoded_pack (decoded_pack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input set, then sample 1 ns after the capturing edge.
    task automatic present(input logic v, input INST i, input logic f, input logic [31:0] pc);
        in_valid = v;
        inst     = i;
        flush    = f;
        in_pc    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        present(1'b1, 32'h12345037, 1'b0, 32'h100);
        present(1'b1, 32'h12345037, 1'b0, 32'h100);
        total_cnt++;
        if (decoded_pack !== '0) $display("FAIL reset_pack got %h want 0", decoded_pack); else pass_cnt++;
        total_cnt++;
        if ({csr_op, halt, illegal} !== 3'b000) $display("FAIL reset_flags got %b want 000", {csr_op, halt, illegal}); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_lui_back_to_back();
        present(1'b1, 32'h12345037, 1'b0, 32'h200);
        total_cnt++;
        if (decoded_pack.valid !== 1'b1 || decoded_pack.dest_reg_idx !== 5'd0 || decoded_pack.imm !== 32'h12345000)
            $display("FAIL lui_fields got v=%b rd=%0d imm=%h want v=1 rd=0 imm=12345000",
                     decoded_pack.valid, decoded_pack.dest_reg_idx, decoded_pack.imm);
        else pass_cnt++;
        total_cnt++;
        if (decoded_pack.opa_select !== OPA_ZERO || decoded_pack.opb_select !== OPB_IMM || illegal !== 1'b0 || halt !== 1'b0)
            $display("FAIL lui_ops got opa=%0d opb=%0d ill=%b halt=%b want opa=2 opb=1 ill=0 halt=0",
                     decoded_pack.opa_select, decoded_pack.opb_select, illegal, halt);
        else pass_cnt++;
        // ADD x3,x1,x2 immediately after
        present(1'b1, 32'h002081B3, 1'b0, 32'h204);
        total_cnt++;
        if (decoded_pack.alu_func !== ALU_ADD || decoded_pack.dest_reg_idx !== 5'd3 || decoded_pack.rs1_idx !== 5'd1
            || decoded_pack.rs2_idx !== 5'd2 || decoded_pack.opb_select !== OPB_RS2 || decoded_pack.pc !== 32'h204)
            $display("FAIL add_fields got alu=%0d rd=%0d rs1=%0d rs2=%0d opb=%0d pc=%h want alu=0 rd=3 rs1=1 rs2=2 opb=0 pc=204",
                     decoded_pack.alu_func, decoded_pack.dest_reg_idx, decoded_pack.rs1_idx,
                     decoded_pack.rs2_idx, decoded_pack.opb_select, decoded_pack.pc);
        else pass_cnt++;
        present(1'b1, 32'h402081B3, 1'b0, 32'h208);
        total_cnt++;
        if (decoded_pack.alu_func !== ALU_SUB || illegal !== 1'b0)
            $display("FAIL sub_alu got alu=%0d ill=%b want alu=1 ill=0", decoded_pack.alu_func, illegal);
        else pass_cnt++;
        present(1'b1, 32'h00001397, 1'b0, 32'h20C);
        total_cnt++;
        if (decoded_pack.opa_select !== OPA_PC || decoded_pack.imm !== 32'h00001000 || decoded_pack.dest_reg_idx !== 5'd7
            || decoded_pack.pc !== 32'h20C)
            $display("FAIL auipc got opa=%0d imm=%h rd=%0d pc=%h want opa=1 imm=1000 rd=7 pc=20c",
                     decoded_pack.opa_select, decoded_pack.imm, decoded_pack.dest_reg_idx, decoded_pack.pc);
        else pass_cnt++;
    endtask

    task automatic test_wfi();
        present(1'b1, 32'h10500073, 1'b0, 32'h300);
        total_cnt++;
        if (halt !== 1'b1 || decoded_pack.halt !== 1'b1 || decoded_pack.dest_reg_idx !== 5'd0 || illegal !== 1'b0 || csr_op !== 1'b0)
            $display("FAIL wfi got halt=%b rd=%0d ill=%b csr=%b want halt=1 rd=0 ill=0 csr=0",
                     halt, decoded_pack.dest_reg_idx, illegal, csr_op);
        else pass_cnt++;
    endtask

    task automatic test_load_flush();
        present(1'b1, 32'hFFC42083, 1'b0, 32'h400);
        total_cnt++;
        if (decoded_pack.rd_mem !== 1'b1 || decoded_pack.rs1_idx !== 5'd8 || decoded_pack.dest_reg_idx !== 5'd1
            || decoded_pack.imm !== 32'hFFFFFFFC || decoded_pack.opb_select !== OPB_IMM)
            $display("FAIL lw got rd_mem=%b rs1=%0d rd=%0d imm=%h opb=%0d want rd_mem=1 rs1=8 rd=1 imm=fffffffc opb=1",
                     decoded_pack.rd_mem, decoded_pack.rs1_idx, decoded_pack.dest_reg_idx,
                     decoded_pack.imm, decoded_pack.opb_select);
        else pass_cnt++;
        present(1'b1, 32'hFFC42083, 1'b1, 32'h404);
        total_cnt++;
        if ({decoded_pack.valid, decoded_pack.rd_mem, decoded_pack.wr_mem, decoded_pack.cond_branch,
             decoded_pack.uncond_branch, csr_op, halt, illegal} !== 8'h00 || decoded_pack.dest_reg_idx !== 5'd0)
            $display("FAIL lw_flush got v=%b rd_mem=%b rd=%0d want v=0 rd_mem=0 rd=0",
                     decoded_pack.valid, decoded_pack.rd_mem, decoded_pack.dest_reg_idx);
        else pass_cnt++;
    endtask

    task automatic test_control_flow();
        present(1'b1, 32'h008000EF, 1'b0, 32'h500);
        total_cnt++;
        if (decoded_pack.uncond_branch !== 1'b1 || decoded_pack.imm !== 32'd8 || decoded_pack.dest_reg_idx !== 5'd1
            || decoded_pack.opa_select !== OPA_PC || decoded_pack.opb_select !== OPB_FOUR)
            $display("FAIL jal got ub=%b imm=%h rd=%0d opa=%0d opb=%0d want ub=1 imm=8 rd=1 opa=1 opb=2",
                     decoded_pack.uncond_branch, decoded_pack.imm, decoded_pack.dest_reg_idx,
                     decoded_pack.opa_select, decoded_pack.opb_select);
        else pass_cnt++;
        present(1'b1, 32'h00209863, 1'b0, 32'h504);
        total_cnt++;
        if (decoded_pack.cond_branch !== 1'b1 || decoded_pack.imm !== 32'd16 || decoded_pack.dest_reg_idx !== 5'd0
            || decoded_pack.uncond_branch !== 1'b0)
            $display("FAIL bne got cb=%b imm=%h rd=%0d ub=%b want cb=1 imm=10 rd=0 ub=0",
                     decoded_pack.cond_branch, decoded_pack.imm, decoded_pack.dest_reg_idx, decoded_pack.uncond_branch);
        else pass_cnt++;
        present(1'b1, 32'h0020A423, 1'b0, 32'h508);
        total_cnt++;
        if (decoded_pack.wr_mem !== 1'b1 || decoded_pack.imm !== 32'd8 || decoded_pack.dest_reg_idx !== 5'd0
            || decoded_pack.rd_mem !== 1'b0)
            $display("FAIL sw got wr=%b imm=%h rd=%0d rd_mem=%b want wr=1 imm=8 rd=0 rd_mem=0",
                     decoded_pack.wr_mem, decoded_pack.imm, decoded_pack.dest_reg_idx, decoded_pack.rd_mem);
        else pass_cnt++;
    endtask

    task automatic test_shift_csr();
        present(1'b1, 32'h40335293, 1'b0, 32'h600);
        total_cnt++;
        if (decoded_pack.alu_func !== ALU_SRA || illegal !== 1'b0 || decoded_pack.dest_reg_idx !== 5'd5)
            $display("FAIL srai got alu=%0d ill=%b rd=%0d want alu=9 ill=0 rd=5",
                     decoded_pack.alu_func, illegal, decoded_pack.dest_reg_idx);
        else pass_cnt++;
        present(1'b1, 32'h02331293, 1'b0, 32'h604);
        total_cnt++;
        if (illegal !== 1'b1 || decoded_pack.dest_reg_idx !== 5'd0)
            $display("FAIL slli_bad got ill=%b rd=%0d want ill=1 rd=0", illegal, decoded_pack.dest_reg_idx);
        else pass_cnt++;
        present(1'b1, 32'h3003D2F3, 1'b0, 32'h608);
        total_cnt++;
        if (csr_op !== 1'b1 || decoded_pack.imm !== 32'd7 || decoded_pack.dest_reg_idx !== 5'd5 || illegal !== 1'b0)
            $display("FAIL csrrwi got csr=%b imm=%h rd=%0d ill=%b want csr=1 imm=7 rd=5 ill=0",
                     csr_op, decoded_pack.imm, decoded_pack.dest_reg_idx, illegal);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        present(1'b1, 32'h00000000, 1'b0, 32'h700);
        total_cnt++;
        if (illegal !== 1'b1 || decoded_pack.illegal !== 1'b1 || decoded_pack.valid !== 1'b1)
            $display("FAIL zero_ill got ill=%b v=%b want ill=1 v=1", illegal, decoded_pack.valid);
        else pass_cnt++;
        total_cnt++;
        if ({decoded_pack.rd_mem, decoded_pack.wr_mem, decoded_pack.cond_branch, decoded_pack.uncond_branch,
             csr_op, halt} !== 6'b0 || decoded_pack.dest_reg_idx !== 5'd0)
            $display("FAIL zero_ctrl got ctrl=%b rd=%0d want 000000 rd=0",
                     {decoded_pack.rd_mem, decoded_pack.wr_mem, decoded_pack.cond_branch,
                      decoded_pack.uncond_branch, csr_op, halt}, decoded_pack.dest_reg_idx);
        else pass_cnt++;
        present(1'b0, 32'h00000000, 1'b0, 32'h704);
        total_cnt++;
        if (illegal !== 1'b0 || decoded_pack.valid !== 1'b0)
            $display("FAIL idle_ill got ill=%b v=%b want ill=0 v=0", illegal, decoded_pack.valid);
        else pass_cnt++;
        present(1'b1, 32'h00000073, 1'b0, 32'h708);
        total_cnt++;
        if (illegal !== 1'b1 || csr_op !== 1'b0)
            $display("FAIL ecall got ill=%b csr=%b want ill=1 csr=0", illegal, csr_op);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        logic exp_ill;
`ifdef DECODER_RV32M_EN
        exp_ill = 1'b0;
`else
        exp_ill = 1'b1;
`endif
        present(1'b1, 32'h02208033, 1'b0, 32'h800);
        total_cnt++;
        if (illegal !== exp_ill) $display("FAIL mul_ill got %b want %b", illegal, exp_ill); else pass_cnt++;
`ifdef DECODER_RV32M_EN
        total_cnt++;
        if (decoded_pack.alu_func !== ALU_MUL) $display("FAIL mul_alu got %0d want 10", decoded_pack.alu_func); else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        present(1'b1, 32'hFFC42083, 1'b0, 32'h900);
        total_cnt++;
        if (decoded_pack.valid !== 1'b1) $display("FAIL pre_rst_valid got %b want 1", decoded_pack.valid); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (decoded_pack !== '0 || illegal !== 1'b0)
            $display("FAIL async_clear got %h want 0", decoded_pack);
        else pass_cnt++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (decoded_pack.valid !== 1'b0) $display("FAIL rel_no_edge got v=%b want 0", decoded_pack.valid); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (decoded_pack.valid !== 1'b1 || decoded_pack.rd_mem !== 1'b1)
            $display("FAIL first_capture got v=%b rd_mem=%b want v=1 rd_mem=1", decoded_pack.valid, decoded_pack.rd_mem);
        else pass_cnt++;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inst     = '0;
        flush    = 1'b0;
        in_pc    = '0;
        test_reset();
        test_lui_back_to_back();
        test_wfi();
        test_load_flush();
        test_control_flow();
        test_shift_csr();
        test_illegal();
        test_mul();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
